// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encoding and grant identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating cycle counter for an outstanding memory request.
// clear: restart; enable: count; expired: count reached TIMEOUT-1.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between fetch (i_*)
// and load/store (d_*) requesters; done pulses carry rdata or timeout err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  state_t state;
  state_t state_n;
  logic   last_grant;

  logic                h_we;
  logic [ADDR_W-1:0]   h_addr;
  logic [DATA_W-1:0]   h_wdata;
  logic [DATA_W/8-1:0] h_wstrb;

  logic i_elig;
  logic d_elig;
  logic grant;
  logic gnt_id;
  logic fin;
  logic fin_err;
  logic expired;
  logic busy;

  assign busy = (state != IDLE);

  // A req still high in its own done cycle is the old request.
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    gnt_id  = GNT_I;
    fin     = 1'b0;
    fin_err = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          i_elig && d_elig: begin
            grant  = 1'b1;
            gnt_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
          end
          d_elig && !i_elig: begin
            grant  = 1'b1;
            gnt_id = GNT_D;
          end
          i_elig && !d_elig: begin
            grant  = 1'b1;
            gnt_id = GNT_I;
          end
          default: ;
        endcase
        if (grant) begin
          state_n = (gnt_id == GNT_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // Ack wins over a simultaneous timeout.
        if (m_ack) begin
          fin = 1'b1;
        end else if (expired) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
        if (fin) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_D;
      h_we       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      h_wstrb    <= '0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant) begin
        if (gnt_id == GNT_D) begin
          h_we    <= d_we;
          h_addr  <= d_addr;
          h_wdata <= d_wdata;
          h_wstrb <= d_wstrb;
        end else begin
          h_we    <= 1'b0;
          h_addr  <= i_addr;
          h_wdata <= '0;
          h_wstrb <= '0;
        end
      end
      if (fin) begin
        if (state == BUSY_I) begin
          i_done     <= 1'b1;
          i_err      <= fin_err;
          i_rdata    <= fin_err ? '0 : m_rdata;
          last_grant <= GNT_I;
        end else begin
          d_done     <= 1'b1;
          d_err      <= fin_err;
          d_rdata    <= fin_err ? '0 : m_rdata;
          last_grant <= GNT_D;
        end
      end
    end
  end

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && !m_ack),
    .expired (expired)
  );

  assign m_req   = busy;
  assign m_we    = h_we;
  assign m_addr  = h_addr;
  assign m_wdata = h_wdata;
  assign m_wstrb = h_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a
// transaction-level reference model (TIMEOUT=8).
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic        i_done;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstrb;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        mack;
  logic [31:0] mrdata;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .i_req   (ireq),
    .i_addr  (iaddr),
    .i_done  (i_done),
    .i_err   (i_err),
    .i_rdata (i_rdata),
    .d_req   (dreq),
    .d_we    (dwe),
    .d_addr  (daddr),
    .d_wdata (dwdata),
    .d_wstrb (dwstrb),
    .d_done  (d_done),
    .d_err   (d_err),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ack   (mack),
    .m_rdata (mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: owner 0=none 1=fetch 2=data; lg 1 means data went last.
  int          own;
  int          waited;
  bit          lg;
  bit          e_idone, e_ddone, e_ierr, e_derr;
  logic [31:0] e_irdata, e_drdata;
  bit          x_we;
  logic [31:0] x_addr, x_wdata;
  logic [3:0]  x_wstrb;

  task automatic model_edge();
    bit pi, pd, ie, de, err;
    int w;
    if (rst) begin
      own = 0; waited = 0; lg = 1'b1;
      e_idone = 0; e_ddone = 0;
      e_irdata = '0; e_drdata = '0;
      return;
    end
    pi = e_idone;
    pd = e_ddone;
    e_idone = 0;
    e_ddone = 0;
    if (own == 0) begin
      ie = ireq && !pi;
      de = dreq && !pd;
      w = 0;
      if (ie && de) w = lg ? 1 : 2;
      else if (ie) w = 1;
      else if (de) w = 2;
      if (w == 1) begin
        own = 1; waited = 0;
        x_we = 0; x_addr = iaddr; x_wdata = '0; x_wstrb = '0;
      end else if (w == 2) begin
        own = 2; waited = 0;
        x_we = dwe; x_addr = daddr; x_wdata = dwdata; x_wstrb = dwstrb;
      end
    end else if (mack || waited == TO - 1) begin
      err = !mack;
      if (own == 1) begin
        e_idone = 1; e_ierr = err; e_irdata = err ? '0 : mrdata;
      end else begin
        e_ddone = 1; e_derr = err; e_drdata = err ? '0 : mrdata;
      end
      lg = (own == 2);
      own = 0;
    end else begin
      waited++;
    end
  endtask

  task automatic compare_all();
    chk("m_req", m_req, own != 0);
    if (own != 0) begin
      chk("m_addr", m_addr, x_addr);
      chk("m_we", m_we, x_we);
      chk("m_wstrb", m_wstrb, x_wstrb);
      if (own == 2) chk("m_wdata", m_wdata, x_wdata);
    end
    chk("i_done", i_done, e_idone);
    chk("d_done", d_done, e_ddone);
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    if (e_idone) chk("i_err", i_err, e_ierr);
    if (e_ddone) chk("d_err", d_err, e_derr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic apply_reset();
    rst = 1; ireq = 0; dreq = 0; mack = 0;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    int cnt, gi, g;
    bit prev;
    rst = 1; ireq = 0; iaddr = '0; dreq = 0; dwe = 0; daddr = '0;
    dwdata = '0; dwstrb = '0; mack = 0; mrdata = '0;
    own = 0; waited = 0; lg = 1;
    x_we = 0; x_addr = '0; x_wdata = '0; x_wstrb = '0;
    e_ierr = 0; e_derr = 0;

    apply_reset();
    chk("rst_mreq", m_req, 0);
    chk("rst_idone", i_done, 0);

    // minimum latency fetch
    ireq = 1; iaddr = 32'h10;
    step();
    chk("t1_mreq", m_req, 1);
    mack = 1; mrdata = 32'h13;
    step();
    mack = 0; ireq = 0;
    chk("t1_idone", i_done, 1);
    chk("t1_rdata", i_rdata, 32'h13);
    chk("t1_mreq_off", m_req, 0);

    // both held: strict alternation starting with fetch
    apply_reset();
    ireq = 1; iaddr = 32'h40; dreq = 1; daddr = 32'h80; dwe = 0;
    gi = 0; prev = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (m_req && !prev) begin
        g = (m_addr == 32'h80) ? 1 : 0;
        chk("t2_order", g, gi % 2);
        gi++;
      end
      if (m_req && prev) chk("t2_gap", 1, 0);
      prev = m_req;
      mack = m_req;
    end
    chk("t2_grants", gi, 8);
    mack = 0; ireq = 0; dreq = 0;
    apply_reset();

    // store with ack in the 3rd busy cycle
    dreq = 1; dwe = 1; daddr = 32'h100; dwdata = 32'hAABBCCDD;
    dwstrb = 4'b0011;
    step();
    step();
    step();
    chk("t3_wstrb", m_wstrb, 4'b0011);
    mack = 1;
    step();
    mack = 0; dreq = 0;
    chk("t3_ddone", d_done, 1);
    chk("t3_derr", d_err, 0);

    // timeout
    apply_reset();
    ireq = 1; iaddr = 32'h200; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_req) cnt++;
      else if (cnt > 0) break;
    end
    ireq = 0;
    chk("t4_busy_cycles", cnt, TO);
    chk("t4_idone", i_done, 1);
    chk("t4_ierr", i_err, 1);
    chk("t4_rdata", i_rdata, 0);
    mack = 1;
    step();
    mack = 0;
    step();
    chk("t4_idle_ack", i_done, 0);

    // ack in the last allowed cycle
    apply_reset();
    ireq = 1; iaddr = 32'h204;
    for (int k = 0; k < TO; k++) step();
    mack = 1; mrdata = 32'h1234;
    step();
    mack = 0; ireq = 0;
    chk("t5_idone", i_done, 1);
    chk("t5_ierr", i_err, 0);
    chk("t5_rdata", i_rdata, 32'h1234);

    // reset mid data transaction, then fetch wins the tie
    apply_reset();
    dreq = 1; dwe = 0; daddr = 32'h300;
    step();
    step();
    rst = 1;
    step();
    chk("t6_mreq", m_req, 0);
    chk("t6_ddone", d_done, 0);
    rst = 0; ireq = 1; iaddr = 32'h400;
    step();
    chk("t6_winner", m_addr, 32'h400);
    mack = 1;
    step();
    mack = 0; ireq = 0;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      mack = m_req ? ($urandom_range(0, 9) < 3)
                   : ($urandom_range(0, 9) == 0);
      mrdata = $urandom;
      if (!ireq || i_done) begin
        ireq = ($urandom_range(0, 2) != 0);
        iaddr = $urandom;
      end
      if (!dreq || d_done) begin
        dreq = ($urandom_range(0, 2) != 0);
        dwe = 1'($urandom);
        daddr = $urandom;
        dwdata = $urandom;
        dwstrb = 4'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified, variable-latency memory port between the core's instruction-fetch requester and its load/store data requester. It grants one requester at a time, round-robin on conflict. It captures the request into holding registers and drives a req/ack handshake to memory. It returns a one-cycle done pulse with read data, or an error if memory fails to acknowledge within TIMEOUT cycles.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobe width = DATA_W/8)
TIMEOUT, 64, max cycles in BUSY without m_ack before error completion (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request; held with i_addr until i_done
i_addr  in  ADDR_W  fetch address
i_done  out  1  one-cycle fetch completion pulse
i_err  out  1  valid with i_done; 1 = timeout
i_rdata  out  DATA_W  fetched word, valid with i_done
d_req  in  1  data request; held with d_* until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data (already lane-aligned)
d_wstrb  in  DATA_W/8  byte enables for stores
d_done  out  1  one-cycle data completion pulse
d_err  out  1  valid with d_done; 1 = timeout
d_rdata  out  DATA_W  load word, valid with d_done
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory byte enables
m_ack  in  1  one-cycle completion from memory
m_rdata  in  DATA_W  read data, valid with m_ack

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Register last_grant in {I, D}.
- Reset: state=IDLE, last_grant=D (fetch wins first tie). All outputs 0, timeout counter 0.
- IDLE, eligibility: a requester is eligible if its req=1 and its done output is 0 this cycle. This masks a req still held in the cycle of its own done.
- IDLE, grant rules:
  - Only D eligible -> grant D.
  - Only I eligible -> grant I.
  - Both eligible -> grant the one not equal to last_grant.
- IDLE, on grant: latch addr/we/wdata/wstrb into holding registers. Fetch forces we=0, wstrb=0. Go to BUSY_x and clear the counter.
- BUSY_x: m_req=1; m_* driven only from holding registers, never combinationally from requester inputs.
- BUSY_x, counter: increments each cycle without m_ack.
- BUSY_x, on m_ack:
  - Next cycle: x_done=1, x_err=0, x_rdata=m_rdata (registered).
  - last_grant<=x; state->IDLE; m_req=0.
- BUSY_x, timeout: counter reaches TIMEOUT-1 with m_ack=0.
  - Next cycle: x_done=1, x_err=1, x_rdata=0.
  - last_grant<=x; IDLE; m_req=0.
- m_ack in the same cycle as the timeout condition -> ack wins, err=0.
- Minimum latency: req sampled in cycle 0 -> m_req in cycle 1 -> m_ack in cycle 1 -> done in cycle 2.
- Back-to-back: done cycle is an IDLE cycle, so the earliest next m_req comes one cycle after done.
- x_rdata holds its value until the next x_done. x_err is meaningful only with x_done.
- m_ack while IDLE: ignored.
- Reset mid-transaction: transaction abandoned, no done pulse, m_req=0 the cycle after reset is sampled.
- Counter width: $clog2(TIMEOUT+1); saturates, never wraps.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2)
  - grant id constants (GNT_I=1'b0, GNT_D=1'b1)
- Sub-module arb_timeout_ctr (clear, enable, expired output; parameter TIMEOUT), instantiated once.

Test Plan:
- i_req=1, i_addr=0x0000_0010, memory acks in cycle 1 with 0x0000_0013 -> m_req high cycle 1 only; i_done=1, i_rdata=0x0000_0013, i_err=0 in cycle 2.
- i_req and d_req both held from reset, ack 1 cycle after each m_req -> grant order I, D, I, D…; exactly one m_req cycle per grant with an IDLE gap.
- d_req store, d_addr=0x100, d_wdata=0xAABB_CCDD, d_wstrb=4'b0011, ack after 3 cycles -> m_we=1, m_wstrb=0011, m_wdata=0xAABB_CCDD stable over all 3 cycles; d_done=1, d_err=0.
- TIMEOUT=8, no ack -> m_req high exactly 8 cycles; i_done=1, i_err=1, i_rdata=0; a later ack while IDLE produces no done.
- TIMEOUT=8, m_ack in the 8th BUSY cycle with m_rdata=0x1234 -> done=1, err=0, rdata=0x1234.
- reset=1 in the 2nd BUSY_D cycle -> m_req=0 next cycle, no d_done, last_grant=D; i_req then wins the first tie.
